// File: rtl/watchdog_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : watchdog_supervisor
//  Purpose  : Gathers subsystem liveness pulses into a single watchdog
//             heartbeat and sequences RF mute, re-arm and lockout on trips.
//  Revision : 1.0  initial release
// ============================================================================
module watchdog_supervisor #(
    parameter int N_SRC      = 4,
    parameter int MUTE_HOLD  = 1024,
    parameter int RETRY_MAX  = 3,
    parameter int HEAL_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sup_enable,
    input  logic [N_SRC-1:0]               src_alive,
    input  logic [N_SRC-1:0]               src_mask,
    input  logic                           wd_warning,
    input  logic                           wd_triggered,
    output logic                           wd_enable,
    output logic                           wd_heartbeat,
    output logic                           wd_force_reset,
    output logic                           rf_mute,
    output logic                           fault_latched,
    output logic [$clog2(RETRY_MAX+1)-1:0] retry_count,
    output logic [N_SRC-1:0]               missing_src
);

    localparam int c_RETRY_W = $clog2(RETRY_MAX + 1);
    localparam int c_HEAL_W  = $clog2(HEAL_BEATS + 1);
    localparam int c_HOLD_W  = $clog2(MUTE_HOLD + 1);

    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = c_RETRY_W'(RETRY_MAX);
    localparam logic [c_HEAL_W-1:0]  c_HEAL_LAST = c_HEAL_W'(HEAL_BEATS - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(MUTE_HOLD - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ARM     = 3'd1;
    localparam logic [2:0] c_RECOVER = 3'd2;
    localparam logic [2:0] c_RUN     = 3'd3;
    localparam logic [2:0] c_MUTE    = 3'd4;
    localparam logic [2:0] c_LOCKOUT = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [N_SRC-1:0]     r_seen;
    logic [N_SRC-1:0]     r_missing;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_HEAL_W-1:0]  r_heal;
    logic [c_RETRY_W-1:0] r_retry;
    logic                 r_wd_enable;
    logic                 r_heartbeat;
    logic                 r_force;
    logic                 r_mute;
    logic                 r_fault;

    logic                 w_ready;
    logic                 w_hold_done;
    logic                 w_beat;
    logic                 w_enable_nxt;
    logic                 w_force_nxt;
    logic                 w_mute_nxt;
    logic                 w_fault_nxt;
    logic                 w_unused;

    // The warning input is informational only; supervision reacts to the trip.
    assign w_unused = wd_warning;

    assign w_ready     = (src_mask != '0) && ((r_seen | ~src_mask) == {N_SRC{1'b1}});
    assign w_hold_done = (r_hold == c_HOLD_LAST);
    // A trip outranks a completed window, so no heartbeat escapes in that cycle.
    assign w_beat      = sup_enable && ((r_state == c_RUN) || (r_state == c_RECOVER))
                         && w_ready && !wd_triggered;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!sup_enable) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:    w_next_state = c_ARM;
                c_ARM:     w_next_state = c_RECOVER;
                c_RECOVER: begin
                    if (wd_triggered) begin
                        w_next_state = c_MUTE;
                    end else if (w_ready) begin
                        w_next_state = c_RUN;
                    end
                end
                c_RUN: begin
                    if (wd_triggered) begin
                        w_next_state = c_MUTE;
                    end
                end
                c_MUTE: begin
                    if (w_hold_done) begin
                        w_next_state = (r_retry == c_RETRY_MAX) ? c_LOCKOUT : c_ARM;
                    end
                end
                c_LOCKOUT: w_next_state = c_LOCKOUT;
                default:   w_next_state = c_IDLE;
            endcase
        end
    end

    // Outputs are registered from the state being entered so that, e.g., the
    // un-mute lands on the same edge as the first heartbeat.
    always_comb begin
        w_enable_nxt = (w_next_state == c_ARM) || (w_next_state == c_RECOVER)
                       || (w_next_state == c_RUN) || (w_next_state == c_MUTE);
        w_force_nxt  = (w_next_state == c_ARM);
        w_mute_nxt   = (w_next_state != c_RUN);
        w_fault_nxt  = (w_next_state == c_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen      <= '0;
            r_missing   <= '0;
            r_hold      <= '0;
            r_heal      <= '0;
            r_retry     <= '0;
            r_wd_enable <= 1'b0;
            r_heartbeat <= 1'b0;
            r_force     <= 1'b0;
            r_mute      <= 1'b1;
            r_fault     <= 1'b0;
        end else begin
            r_wd_enable <= w_enable_nxt;
            r_heartbeat <= w_beat;
            r_force     <= w_force_nxt;
            r_mute      <= w_mute_nxt;
            r_fault     <= w_fault_nxt;
            r_missing   <= src_mask & ~r_seen;

            // A pulse coinciding with a heartbeat seeds the following window.
            if (!sup_enable || (r_state == c_IDLE) || (r_state == c_ARM)) begin
                r_seen <= '0;
            end else if (w_beat) begin
                r_seen <= src_alive & src_mask;
            end else begin
                r_seen <= r_seen | (src_alive & src_mask);
            end

            if (sup_enable && (r_state == c_MUTE) && !w_hold_done) begin
                r_hold <= r_hold + c_HOLD_W'(1);
            end else begin
                r_hold <= '0;
            end

            if (r_state != c_RUN) begin
                r_heal <= '0;
            end else if (w_beat) begin
                r_heal <= (r_heal == c_HEAL_LAST) ? '0 : r_heal + c_HEAL_W'(1);
            end

            if (!sup_enable || (r_state == c_IDLE)) begin
                r_retry <= '0;
            end else if ((r_state == c_MUTE) && w_hold_done && (r_retry != c_RETRY_MAX)) begin
                r_retry <= r_retry + c_RETRY_W'(1);
            end else if ((r_state == c_RUN) && w_beat && (r_heal == c_HEAL_LAST)) begin
                r_retry <= '0;
            end
        end
    end

    assign wd_enable      = r_wd_enable;
    assign wd_heartbeat   = r_heartbeat;
    assign wd_force_reset = r_force;
    assign rf_mute        = r_mute;
    assign fault_latched  = r_fault;
    assign retry_count    = r_retry;
    assign missing_src    = r_missing;

endmodule
`default_nettype wire
